// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with PC alias and pending-write scoreboard
//
// Purpose: NREGS = 2**ADDR_W - 1 general registers. Index 2**ADDR_W - 1 is the PC alias,
//          which reads r15 and ignores writes and issues. Three combinational read ports and
//          two write ports are provided. A per-register pending bit marks destinations of
//          multicycle ops that have been issued but not yet written back.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read
//          ports and to mask busy for registers being written without a same-cycle re-issue.
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   ra1..ra3 / rd1..rd3   read addresses / combinational read data
//   busy1..busy3          read register has a pending write (0 for the PC alias)
//   we3, wa3, wd3         primary write port (wins when both ports hit one register)
//   we4, wa4, wd4         secondary write port (long-multiply high half)
//   r15                   PC+8 value returned for the alias index
//   iss_valid, iss_wa     issue of a multicycle op, destination marked pending
//   iss_long, iss_wa4     also mark a second destination pending
//   pend_any              OR of all registered pending bits
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    output logic              busy1,
    output logic              busy2,
    output logic              busy3,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic [DATA_W-1:0] r15,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_wa,
    input  logic              iss_long,
    input  logic [ADDR_W-1:0] iss_wa4,
    output logic              pend_any
);

    localparam int NREGS = (2 ** ADDR_W) - 1;
    localparam logic [ADDR_W-1:0] PC_IDX = '1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pend_nxt;
    logic [NREGS-1:0]  wr_hit;
    logic [NREGS-1:0]  iss_hit;

    logic [ADDR_W-1:0] ra_v   [3];
    logic [DATA_W-1:0] rd_v   [3];
    logic              busy_v [3];

    assign ra_v[0] = ra1;
    assign ra_v[1] = ra2;
    assign ra_v[2] = ra3;
    assign rd1     = rd_v[0];
    assign rd2     = rd_v[1];
    assign rd3     = rd_v[2];
    assign busy1   = busy_v[0];
    assign busy2   = busy_v[1];
    assign busy3   = busy_v[2];

    assign pend_any = |pending;

    // Per-register write and issue decode. The alias index never matches a physical
    // register, so alias writes and issues fall out with no extra logic.
    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i]  = (we3 && (wa3 == ADDR_W'(i))) || (we4 && (wa4 == ADDR_W'(i)));
            iss_hit[i] = iss_valid &&
                         ((iss_wa == ADDR_W'(i)) || (iss_long && (iss_wa4 == ADDR_W'(i))));
        end
        // Issue beats writeback so a re-issued register stays pending.
        pend_nxt = iss_hit | (pending & ~wr_hit);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we3 && (wa3 == ADDR_W'(i))) begin
                    regs[i] <= wd3;
                end else if (we4 && (wa4 == ADDR_W'(i))) begin
                    regs[i] <= wd4;
                end
            end
            pending <= pend_nxt;
        end
    end

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_v[p]   = '0;
            busy_v[p] = 1'b0;
            if (ra_v[p] == PC_IDX) begin
                rd_v[p] = r15;
            end else begin
                rd_v[p]   = regs[ra_v[p]];
                busy_v[p] = pending[ra_v[p]];
`ifdef REGFILE_BYPASS_EN
                if (we3 && (wa3 == ra_v[p])) begin
                    rd_v[p] = wd3;
                end else if (we4 && (wa4 == ra_v[p])) begin
                    rd_v[p] = wd4;
                end
                if (wr_hit[ra_v[p]] && !iss_hit[ra_v[p]]) begin
                    busy_v[p] = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  ra1, ra2, ra3, wa3, wa4, iss_wa, iss_wa4;
    logic [31:0] rd1, rd2, rd3, wd3, wd4, r15;
    logic        busy1, busy2, busy3, we3, we4, iss_valid, iss_long, pend_any;

    logic [4:0]  w_ra1, w_ra2, w_ra3, w_wa3, w_wa4, w_iss_wa, w_iss_wa4;
    logic [63:0] w_rd1, w_rd2, w_rd3, w_wd3, w_wd4, w_r15;
    logic        w_busy1, w_busy2, w_busy3, w_we3, w_we4, w_iss_valid, w_iss_long, w_pend_any;

    int total = 0;
    int bad = 0;

    logic [31:0] m_regs [15];
    logic        m_pend [15];

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .ra1(ra1), .ra2(ra2), .ra3(ra3), .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .busy1(busy1), .busy2(busy2), .busy3(busy3),
        .we3(we3), .wa3(wa3), .wd3(wd3), .we4(we4), .wa4(wa4), .wd4(wd4),
        .r15(r15), .iss_valid(iss_valid), .iss_wa(iss_wa), .iss_long(iss_long),
        .iss_wa4(iss_wa4), .pend_any(pend_any)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(5)) u_wide (
        .clk(clk), .reset_n(reset_n),
        .ra1(w_ra1), .ra2(w_ra2), .ra3(w_ra3), .rd1(w_rd1), .rd2(w_rd2), .rd3(w_rd3),
        .busy1(w_busy1), .busy2(w_busy2), .busy3(w_busy3),
        .we3(w_we3), .wa3(w_wa3), .wd3(w_wd3), .we4(w_we4), .wa4(w_wa4), .wd4(w_wd4),
        .r15(w_r15), .iss_valid(w_iss_valid), .iss_wa(w_iss_wa), .iss_long(w_iss_long),
        .iss_wa4(w_iss_wa4), .pend_any(w_pend_any)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 15; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [3:0] ra);
        if (ra == 4'd15) return r15;
`ifdef REGFILE_BYPASS_EN
        if (we3 && wa3 == ra) return wd3;
        if (we4 && wa4 == ra) return wd4;
`endif
        return m_regs[ra];
    endfunction

    function automatic logic exp_busy(input logic [3:0] ra);
        if (ra == 4'd15) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((we3 && wa3 == ra) || (we4 && wa4 == ra)) &&
            !(iss_valid && (iss_wa == ra || (iss_long && iss_wa4 == ra)))) return 1'b0;
`endif
        return m_pend[ra];
    endfunction

    function automatic logic exp_pend_any();
        logic any = 1'b0;
        for (int i = 0; i < 15; i++) any = any | m_pend[i];
        return any;
    endfunction

    // Compare all outputs against the model, then clock and apply the spec's update rules.
    task automatic cycle();
        #1;
        check("rd1", rd1, exp_rd(ra1));
        check("rd2", rd2, exp_rd(ra2));
        check("rd3", rd3, exp_rd(ra3));
        check("busy1", busy1, exp_busy(ra1));
        check("busy2", busy2, exp_busy(ra2));
        check("busy3", busy3, exp_busy(ra3));
        check("pend_any", pend_any, exp_pend_any());
        @(posedge clk);
        if (we4 && wa4 != 4'd15) begin m_regs[wa4] = wd4; m_pend[wa4] = 1'b0; end
        if (we3 && wa3 != 4'd15) begin m_regs[wa3] = wd3; m_pend[wa3] = 1'b0; end
        if (iss_valid && iss_wa != 4'd15) m_pend[iss_wa] = 1'b1;
        if (iss_valid && iss_long && iss_wa4 != 4'd15) m_pend[iss_wa4] = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        we3 = 0; we4 = 0; iss_valid = 0; iss_long = 0;
        w_we3 = 0; w_we4 = 0; w_iss_valid = 0; w_iss_long = 0;
    endtask

    initial begin
        idle();
        ra1 = 0; ra2 = 0; ra3 = 0; wa3 = 0; wa4 = 0; wd3 = 0; wd4 = 0;
        iss_wa = 0; iss_wa4 = 0; r15 = 32'h8;
        w_ra1 = 0; w_ra2 = 0; w_ra3 = 0; w_wa3 = 0; w_wa4 = 0; w_wd3 = 0; w_wd4 = 0;
        w_iss_wa = 0; w_iss_wa4 = 0; w_r15 = 64'h8;
        model_clear();

        @(negedge clk);
        #1;
        check("reset_rd1", rd1, 32'h0);
        check("reset_busy1", busy1, 1'b0);
        check("reset_pend_any", pend_any, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Dual write, then same-address collision
        we3 = 1; wa3 = 2; wd3 = 32'hAAAA0000; we4 = 1; wa4 = 5; wd4 = 32'h0000BBBB;
        cycle();
        idle(); ra1 = 2; ra2 = 5; #1;
        check("dual_r2", rd1, 32'hAAAA0000);
        check("dual_r5", rd2, 32'h0000BBBB);
        we3 = 1; wa3 = 7; wd3 = 32'h77; we4 = 1; wa4 = 7; wd4 = 32'h88;
        cycle();
        idle(); ra3 = 7; #1;
        check("collide_r7", rd3, 32'h77);

        // PC alias reads r15, writes to it are dropped
        ra1 = 15; r15 = 32'h108; #1;
        check("alias_rd", rd1, 32'h108);
        check("alias_busy", busy1, 1'b0);
        we3 = 1; wa3 = 15; wd3 = 32'hFF;
        cycle();
        idle(); r15 = 32'h10C; ra2 = 2; #1;
        check("alias_track", rd1, 32'h10C);
        check("alias_nowrite", rd2, 32'hAAAA0000);

        // Scoreboard set / clear / set-wins
        iss_valid = 1; iss_wa = 4; iss_long = 1; iss_wa4 = 9;
        cycle();
        idle(); ra1 = 4; ra2 = 9; #1;
        check("sb_busy4", busy1, 1'b1);
        check("sb_busy9", busy2, 1'b1);
        check("sb_pend_any", pend_any, 1'b1);
        we3 = 1; wa3 = 4; wd3 = 32'h44;
        cycle();
        idle(); #1;
        check("sb_clr4", busy1, 1'b0);
        check("sb_keep9", busy2, 1'b1);
        we3 = 1; wa3 = 4; wd3 = 32'h45; iss_valid = 1; iss_wa = 4;
        cycle();
        idle(); #1;
        check("sb_setwins", busy1, 1'b1);

        // Same-cycle write and read of a pending register
        we3 = 1; wa3 = 6; wd3 = 32'h11; iss_valid = 1; iss_wa = 6;
        cycle();
        idle(); we3 = 1; wa3 = 6; wd3 = 32'h55; ra2 = 6; #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_rd2", rd2, 32'h55);
        check("byp_busy2", busy2, 1'b0);
`else
        check("nobyp_rd2", rd2, 32'h11);
        check("nobyp_busy2", busy2, 1'b1);
`endif
        cycle();
        idle();

        // Wide instance: 31 registers, alias at 31
        w_we3 = 1; w_wa3 = 30; w_wd3 = 64'hDEADBEEF01234567;
        w_iss_valid = 1; w_iss_wa = 29;
        cycle();
        idle(); w_ra1 = 30; w_ra2 = 31; w_ra3 = 29; w_r15 = 64'h1_0000_0108; #1;
        check("wide_r30", w_rd1, 64'hDEADBEEF01234567);
        check("wide_alias", w_rd2, 64'h1_0000_0108);
        check("wide_busy29", w_busy3, 1'b1);
        w_we3 = 1; w_wa3 = 31; w_wd3 = 64'h0;
        cycle();
        idle(); #1;
        check("wide_r30_kept", w_rd1, 64'hDEADBEEF01234567);
        check("wide_alias_busy", w_busy2, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ra1 = 4'($urandom_range(0, 15)); ra2 = 4'($urandom_range(0, 15));
            ra3 = 4'($urandom_range(0, 15)); r15 = $urandom;
            we3 = ($urandom_range(0, 1) == 1); wa3 = 4'($urandom_range(0, 15)); wd3 = $urandom;
            we4 = ($urandom_range(0, 2) == 0); wa4 = 4'($urandom_range(0, 15)); wd4 = $urandom;
            iss_valid = ($urandom_range(0, 3) == 0); iss_wa = 4'($urandom_range(0, 15));
            iss_long = ($urandom_range(0, 1) == 1); iss_wa4 = 4'($urandom_range(0, 15));
            cycle();
        end
        idle();

        // Asynchronous reset mid-run
        we3 = 1; wa3 = 3; wd3 = 32'h1234; iss_valid = 1; iss_wa = 3;
        cycle();
        idle(); ra1 = 3; #1;
        check("pre_reset_r3", rd1, 32'h1234);
        check("pre_reset_busy", busy1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rd1", rd1, 32'h0);
        check("async_busy1", busy1, 1'b0);
        check("async_pend_any", pend_any, 1'b0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ra1 = 4'($urandom_range(0, 15)); ra2 = 3; ra3 = 15;
            we3 = ($urandom_range(0, 1) == 1); wa3 = 4'($urandom_range(0, 15)); wd3 = $urandom;
            iss_valid = ($urandom_range(0, 1) == 1); iss_wa = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
